// File: rtl/blink_checker.sv
// Measures the clock-cycle spacing of transitions on an asynchronous blink input
// and flags intervals that are too short (fast) or missing (slow), with a lock indicator.
module blink_checker #(
  parameter int unsigned FREQUENCY  = 25_000_000,
  parameter int unsigned SECONDS    = 1,
  parameter int unsigned TOLERANCE  = 1000,
  parameter int unsigned LOCK_COUNT = 4,
  localparam int unsigned H  = FREQUENCY * SECONDS,
  localparam int unsigned CW = $clog2(H + TOLERANCE + 2)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          blink_i,
  output logic [CW-1:0] period_o,
  output logic          valid_o,
  output logic          fast_o,
  output logic          slow_o,
  output logic          locked_o
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] FAST_LIM = CW'(H - TOLERANCE);
  localparam logic [CW-1:0] TMO_CNT  = CW'(H + TOLERANCE + 1);
  localparam logic [GW-1:0] LOCK_LIM = GW'(LOCK_COUNT);

  typedef enum logic [0:0] {IDLE, MEASURE} state_t;

  state_t        state;
  logic          sync_s1;
  logic          sync_s2;
  logic          prev;
  logic          edge_det;
  logic [CW-1:0] cnt;
  logic [GW-1:0] good_cnt;
  logic [GW-1:0] good_inc;

  assign edge_det = sync_s2 ^ prev;

  // Saturating increment so the good-interval count never wraps past LOCK_COUNT
  always_comb begin
    good_inc = good_cnt;
    if (good_cnt != LOCK_LIM) begin
      good_inc = good_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      sync_s1  <= 1'b0;
      sync_s2  <= 1'b0;
      prev     <= 1'b0;
      cnt      <= '0;
      good_cnt <= '0;
      period_o <= '0;
      valid_o  <= 1'b0;
      fast_o   <= 1'b0;
      slow_o   <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      sync_s1 <= blink_i;
      sync_s2 <= sync_s1;
      prev    <= sync_s2;
      valid_o <= 1'b0;
      fast_o  <= 1'b0;
      slow_o  <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (edge_det) begin
            state <= MEASURE;
            cnt   <= CW'(1);
          end
        end

        MEASURE: begin
          // Timeout wins over a coincident edge; that edge is dropped and the next one restarts
          if (cnt == TMO_CNT) begin
            valid_o  <= 1'b1;
            slow_o   <= 1'b1;
            period_o <= TMO_CNT;
            good_cnt <= '0;
            locked_o <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end else if (edge_det) begin
            valid_o  <= 1'b1;
            period_o <= cnt;
            cnt      <= CW'(1);
            if (cnt < FAST_LIM) begin
              fast_o   <= 1'b1;
              good_cnt <= '0;
              locked_o <= 1'b0;
            end else begin
              good_cnt <= good_inc;
              if (good_inc == LOCK_LIM) begin
                locked_o <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_checker.sv
// Directed bench for blink_checker (H=10, TOLERANCE=2, LOCK_COUNT=3): the stimulus
// pushes expected pulses into a queue, a negedge monitor pops and compares them.
module tb_blink_checker;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       blink_i = 1'b0;
  logic [3:0] period_o;
  logic       valid_o;
  logic       fast_o;
  logic       slow_o;
  logic       locked_o;

  blink_checker #(
    .FREQUENCY (10),
    .SECONDS   (1),
    .TOLERANCE (2),
    .LOCK_COUNT(3)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .blink_i (blink_i),
    .period_o(period_o),
    .valid_o (valid_o),
    .fast_o  (fast_o),
    .slow_o  (slow_o),
    .locked_o(locked_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int period;
    bit fast;
    bit slow;
    bit locked;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  bit   done     = 1'b0;
  bit   fin      = 1'b0;
  int   last_tog = 0;

  task automatic push(input int c, input int p, input bit f, input bit s, input bit l);
    exp_t e;
    e.cyc = c; e.period = p; e.fast = f; e.slow = s; e.locked = l;
    q.push_back(e);
  endtask

  // Wait gap cycles after the previous toggle, then toggle. A toggle applied at cycle P
  // yields its valid_o at cycle P+3; a timeout shows up 16 cycles after the last measured toggle.
  task automatic tog(input int gap, input bit pre_slow, input bit val, input int per,
                     input bit f, input bit l);
    if (pre_slow) push(last_tog + 16, 13, 1'b0, 1'b1, 1'b0);
    repeat (gap) @(posedge clk_i);
    #1;
    blink_i  = ~blink_i;
    last_tog = cyc;
    if (val) push(cyc + 3, per, f, 1'b0, l);
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      checks++;
      if (valid_o || fast_o || slow_o || locked_o || period_o != 4'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d: got valid=%0b fast=%0b slow=%0b locked=%0b period=%0d, expected all 0",
                 cyc, valid_o, fast_o, slow_o, locked_o, period_o);
      end
    end else begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_valid: expected pulse at cyc=%0d period=%0d, no pulse by cyc=%0d",
                 q[0].cyc, q[0].period, cyc);
        void'(q.pop_front());
      end
      if (valid_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid cyc=%0d: got period=%0d fast=%0b slow=%0b, expected no pulse",
                   cyc, period_o, fast_o, slow_o);
        end else begin
          mon_e = q.pop_front();
          checks += 5;
          if (cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL valid_cycle: got cyc=%0d, expected cyc=%0d", cyc, mon_e.cyc);
          end
          if (int'(period_o) != mon_e.period) begin
            errors++;
            $display("FAIL period cyc=%0d: got %0d, expected %0d", cyc, period_o, mon_e.period);
          end
          if (fast_o != mon_e.fast) begin
            errors++;
            $display("FAIL fast cyc=%0d: got %0b, expected %0b", cyc, fast_o, mon_e.fast);
          end
          if (slow_o != mon_e.slow) begin
            errors++;
            $display("FAIL slow cyc=%0d: got %0b, expected %0b", cyc, slow_o, mon_e.slow);
          end
          if (locked_o != mon_e.locked) begin
            errors++;
            $display("FAIL locked cyc=%0d: got %0b, expected %0b", cyc, locked_o, mon_e.locked);
          end
        end
      end else begin
        checks++;
        if (fast_o || slow_o) begin
          errors++;
          $display("FAIL flag_qualify cyc=%0d: got fast=%0b slow=%0b without valid, expected 0",
                   cyc, fast_o, slow_o);
        end
      end
    end
    if (done && !fin) begin
      checks += 2;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL pending_expect: got %0d unmatched entries, expected 0", q.size());
      end
      if (locked_o != 1'b0) begin
        errors++;
        $display("FAIL final_locked: got %0b, expected 0", locked_o);
      end
      fin = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held while blink_i toggles: monitor requires all outputs at 0
    rst_ni  = 1'b0;
    blink_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(posedge clk_i);
      #2 blink_i = ~blink_i;
    end
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1 last_tog = cyc;

    // 30 static cycles, then a first edge that produces no measurement
    tog(30, 0, 0, 0, 0, 0);
    tog(10, 0, 1, 10, 0, 0);
    tog(10, 0, 1, 10, 0, 0);
    tog(10, 0, 1, 10, 0, 1);
    tog(10, 0, 1, 10, 0, 1);

    // Tolerance limits stay locked; 7 is fast and drops lock; relock after three good
    tog(8,  0, 1, 8,  0, 1);
    tog(12, 0, 1, 12, 0, 1);
    tog(7,  0, 1, 7,  1, 0);
    tog(10, 0, 1, 10, 0, 0);
    tog(10, 0, 1, 10, 0, 0);
    tog(10, 0, 1, 10, 0, 1);

    // Stop toggling: timeout, then restart edge, then measurement resumes
    tog(20, 1, 0, 0,  0, 0);
    tog(10, 0, 1, 10, 0, 0);
    tog(10, 0, 1, 10, 0, 0);
    tog(10, 0, 1, 10, 0, 1);

    // Edge at cnt==12 is good; edge at cnt==13 coincides with the timeout and is dropped
    tog(12, 0, 1, 12, 0, 1);
    tog(13, 1, 0, 0,  0, 0);
    tog(20, 0, 0, 0,  0, 0);
    tog(10, 0, 1, 10, 0, 0);
    tog(10, 0, 1, 10, 0, 0);
    tog(10, 0, 1, 10, 0, 1);

    // Asynchronous reset mid-count while locked; the next negedge precedes any posedge
    repeat (5) @(posedge clk_i);
    #2;
    rst_ni  = 1'b0;
    blink_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1 last_tog = cyc;
    tog(20, 0, 0, 0,  0, 0);
    tog(10, 0, 1, 10, 0, 0);

    repeat (8) @(posedge clk_i);
    done = 1'b1;
    wait (fin);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
